// File: rtl/mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder_pkg: shared types and address-fault decode             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_resp_state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

  localparam logic [3:0] MEM_WSTRB_WORD = 4'b1111;

  // 33-bit upper bound so a window ending at 4 GiB does not wrap.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [32:0] span);
    logic [32:0] limit;
    limit = {1'b0, base} + span;
    return (addr[1:0] != 2'b00) || (addr < base) || ({1'b0, addr} >= limit);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_sram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_sram: single-port word array, byte write enables, registered read|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_sram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wstrb,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        if (wstrb == MEM_WSTRB_WORD) begin
          mem[addr] <= wdata;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (wstrb[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_responder: single-outstanding memory responder, fixed wait states|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_wstrb_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  mem_resp_state_t state, nxt;
  mem_req_t        req, acc;
  logic [3:0]      cnt;
  logic            accept, acc_en, acc_err, rd_sel, err_q;
  logic [AW-1:0]   widx;
  logic [31:0]     sram_rdata;

  assign accept = req_valid_i && (state == IDLE);

  // The array read is registered, so the access is launched on the edge
  // that enters RESP; with zero latency that is the acceptance edge itself.
  always_comb begin
    nxt    = state;
    acc    = req;
    acc_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            nxt    = RESP;
            acc_en = 1'b1;
            acc    = '{we: req_we_i, addr: req_addr_i,
                       wdata: req_wdata_i, wstrb: req_wstrb_i};
          end else begin
            nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          nxt    = RESP;
          acc_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign acc_err = addr_fault(acc.addr, BASE_ADDR, SPAN);
  assign widx    = AW'((acc.addr - BASE_ADDR) >> 2);

  mem_sram #(.DEPTH_WORDS(DEPTH_WORDS)) u_sram (
    .clk   (clk_i),
    .en    (acc_en && !acc_err),
    .we    (acc.we),
    .addr  (widx),
    .wdata (acc.wdata),
    .wstrb (acc.wstrb),
    .rdata (sram_rdata)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state  <= IDLE;
      req    <= '0;
      cnt    <= 4'd0;
      rd_sel <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        req <= '{we: req_we_i, addr: req_addr_i,
                 wdata: req_wdata_i, wstrb: req_wstrb_i};
        cnt <= LAT_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (acc_en) begin
        rd_sel <= !acc.we && !acc_err;
        err_q  <= acc_err;
      end else if (state == RESP && rsp_ready_i) begin
        rd_sel <= 1'b0;
        err_q  <= 1'b0;
      end
    end
  end

  assign req_ready_o = (state == IDLE);
  assign rsp_valid_o = (state == RESP);
  assign rsp_rdata_o = rd_sel ? sram_rdata : 32'h0;
  assign rsp_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_responder: scoreboard bench, LATENCY=2 and LATENCY=0 builds   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: defaults (1024 words, LATENCY 2, base 0).
  logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 1;
  logic [31:0] a_req_addr = 0, a_req_wdata = 0;
  logic [3:0]  a_req_wstrb = 0;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  // Instance B: 64 words, LATENCY 0, base 0x1000.
  logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 1;
  logic [31:0] b_req_addr = 0, b_req_wdata = 0;
  logic [3:0]  b_req_wstrb = 0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  mem_responder dut_a (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_we_i(a_req_we), .req_addr_i(a_req_addr),
    .req_wdata_i(a_req_wdata), .req_wstrb_i(a_req_wstrb),
    .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready),
    .rsp_rdata_o(a_rsp_rdata), .rsp_err_o(a_rsp_err)
  );

  mem_responder #(.DEPTH_WORDS(64), .LATENCY(0), .BASE_ADDR(32'h0000_1000)) dut_b (
    .clk_i(clk), .reset_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_we_i(b_req_we), .req_addr_i(b_req_addr),
    .req_wdata_i(b_req_wdata), .req_wstrb_i(b_req_wstrb),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_rdata_o(b_rsp_rdata), .rsp_err_o(b_rsp_err)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [31:0] mdl_a [1024];
  logic [31:0] mdl_b [64];

  // Reference model: applies the access to the mirror and returns the response.
  function automatic exp_t model(input bit sel, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] wstrb);
    exp_t        e;
    logic [63:0] base, span, a64;
    int          idx;
    base  = sel ? 64'h1000 : 64'h0;
    span  = sel ? 64'd256 : 64'd4096;
    a64   = {32'h0, addr};
    e.err = (addr[1:0] != 2'b00) || (a64 < base) || (a64 >= base + span);
    e.rdata = 32'h0;
    if (!e.err) begin
      idx = int'((a64 - base) >> 2);
      if (we) begin
        for (int k = 0; k < 4; k++) begin
          if (wstrb[k]) begin
            if (sel) mdl_b[idx][8*k +: 8] = wdata[8*k +: 8];
            else     mdl_a[idx][8*k +: 8] = wdata[8*k +: 8];
          end
        end
      end else begin
        e.rdata = sel ? mdl_b[idx] : mdl_a[idx];
      end
    end
    return e;
  endfunction

  // Issues one request, waits for its response with rsp_ready held high.
  // lat = clock edges from the acceptance edge until rsp_valid is visible.
  task automatic drive(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb,
                       output logic [31:0] rd, output logic er,
                       output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; rd = 32'h0; er = 1'b0; n = 0;
    @(negedge clk);
    if (sel) begin
      b_req_valid = 1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_wstrb = wstrb;
    end else begin
      a_req_valid = 1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_wstrb = wstrb;
    end
    while (!(sel ? b_req_ready : a_req_ready) && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) ok = 1'b0;
    @(posedge clk); #1;
    a_req_valid = 0; b_req_valid = 0;
    @(negedge clk);
    while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 40) begin
      @(negedge clk); lat++;
    end
    if (lat >= 40) ok = 1'b0;
    rd = sel ? b_rsp_rdata : a_rsp_rdata;
    er = sel ? b_rsp_err : a_rsp_err;
    @(posedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    checks++;
    if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0 || b_rsp_rdata !== 32'h0 || b_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: ready=%b valid=%b, required 1 0", a_req_ready, a_rsp_valid);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    sb.push_back(model(0, 1, 32'h10, 32'h1234_5678, 4'hF));
    drive(0, 1, 32'h10, 32'h1234_5678, 4'hF, rd, er, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err || lat != 2) begin
      errors++;
      $display("FAIL store_full: rdata=%h err=%b lat=%0d ok=%b, required %h %b 2", rd, er, lat, ok, e.rdata, e.err);
    end
    sb.push_back(model(0, 0, 32'h10, 32'h0, 4'h0));
    drive(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err || lat != 2) begin
      errors++;
      $display("FAIL load_after_store: rdata=%h err=%b lat=%0d ok=%b, required %h %b 2", rd, er, lat, ok, e.rdata, e.err);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e; bit seen;
    @(negedge clk);
    a_req_valid = 1; a_req_we = 1; a_req_addr = 32'h10; a_req_wdata = 32'hDEAD_BEEF; a_req_wstrb = 4'hF;
    @(posedge clk); #1;
    a_req_valid = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_rsp_rdata !== 32'h0 || a_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: ready=%b valid=%b rdata=%h err=%b, required 1 0 00000000 0",
               a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (a_rsp_valid) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_drop_rsp: rsp_valid seen=1, required 0");
    end
    sb.push_back(model(0, 0, 32'h10, 32'h0, 4'h0));
    drive(0, 0, 32'h10, 32'h0, 4'h0, rd, er, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || rd !== e.rdata || er !== e.err) begin
      errors++;
      $display("FAIL reset_no_write: rdata=%h err=%b ok=%b, required %h %b", rd, er, ok, e.rdata, e.err);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    logic        we_t [4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] wd_t [4]  = '{32'h0000_00AA, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [3:0]  ws_t [4]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(model(0, we_t[i], 32'h10, wd_t[i], ws_t[i]));
      drive(0, we_t[i], 32'h10, wd_t[i], ws_t[i], rd, er, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL partial_store[%0d]: rdata=%h err=%b ok=%b, required %h %b", i, rd, er, ok, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
    bit          sel_t [8] = '{0, 0, 0, 0, 0, 0, 1, 1};
    logic        we_t  [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
    logic [31:0] ad_t  [8] = '{32'h0, 32'h12, 32'h12, 32'h1000, 32'h0, 32'h10, 32'h0FFC, 32'h1100};
    logic [31:0] wd_t  [8] = '{32'hCAFE_F00D, 0, 32'h1111_1111, 32'h2222_2222, 0, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      sb.push_back(model(sel_t[i], we_t[i], ad_t[i], wd_t[i], 4'hF));
      drive(sel_t[i], we_t[i], ad_t[i], wd_t[i], 4'hF, rd, er, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rd !== e.rdata || er !== e.err) begin
        errors++;
        $display("FAIL addr_err[%0d] addr=%h: rdata=%h err=%b ok=%b, required %h %b",
                 i, ad_t[i], rd, er, ok, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, cap_rd; logic er, cap_er; int lat, n; bit ok; exp_t e;
    sb.push_back(model(0, 1, 32'h20, 32'h55AA_33CC, 4'hF));
    drive(0, 1, 32'h20, 32'h55AA_33CC, 4'hF, rd, er, lat, ok);
    e = sb.pop_front();
    sb.push_back(model(0, 0, 32'h20, 32'h0, 4'h0));
    @(negedge clk);
    a_rsp_ready = 0;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 32'h20;
    @(posedge clk); #1;
    a_req_valid = 0;
    n = 0;
    @(negedge clk);
    while (!a_rsp_valid && n < 40) begin @(negedge clk); n++; end
    cap_rd = a_rsp_rdata; cap_er = a_rsp_err;
    e = sb.pop_front();
    checks++;
    if (n >= 40 || cap_rd !== e.rdata || cap_er !== e.err) begin
      errors++;
      $display("FAIL bp_rsp: rdata=%h err=%b wait=%0d, required %h %b", cap_rd, cap_er, n, e.rdata, e.err);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== cap_rd || a_rsp_err !== cap_er || a_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 %h %b 0",
                 c, a_rsp_valid, a_rsp_rdata, a_rsp_err, a_req_ready, cap_rd, cap_er);
      end
    end
    a_rsp_ready = 1;
    @(negedge clk);
    checks++;
    if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 1", a_rsp_valid, a_req_ready);
    end
  endtask

  task automatic test_latency0_random();
    logic [31:0] rd, addr, wd; logic er, we; logic [3:0] ws; int lat; bit ok; exp_t e;
    for (int i = 0; i < 164; i++) begin
      wd = $urandom;
      if (i < 64) begin
        we = 1; ws = 4'hF; addr = 32'h1000 + 32'(i) * 4;
      end else begin
        we = 1'($urandom_range(0, 1));
        ws = 4'($urandom_range(0, 15));
        addr = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
        case ($urandom_range(0, 9))
          0: addr = addr + 32'd2;
          1: addr = 32'h0FFC;
          2: addr = 32'h1100;
          default: ;
        endcase
      end
      sb.push_back(model(1, we, addr, wd, ws));
      drive(1, we, addr, wd, ws, rd, er, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || rd !== e.rdata || er !== e.err || lat != 0) begin
        errors++;
        $display("FAIL lat0_rand[%0d] we=%b addr=%h: rdata=%h err=%b lat=%0d, required %h %b 0",
                 i, we, addr, rd, er, lat, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_store_load();
    test_reset_mid_wait();
    test_partial_store();
    test_errors();
    test_backpressure();
    test_latency0_random();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
